// File: rtl/contador_programa.sv
// Program counter with halt/resume control, sticky error flag and optional return stack.
// Define CONTADOR_PILHA_RETORNO_EN to build the return stack used by chamada/retorno.
module contador_programa #(
   parameter int PC_INICIAL         = 0,
   parameter int ULTIMO_ENDERECO    = 41,
   parameter int PROFUNDIDADE_PILHA = 4
) (
   input  logic       clk_PC,
   input  logic       reset,
   input  logic       stall,
   input  logic       desvio,
   input  logic       salto,
   input  logic       chamada,
   input  logic       retorno,
   input  logic [5:0] alvo,
   input  logic       parar,
   input  logic       retomar,
   output logic [5:0] pc,
   output logic       pc_valido,
   output logic       erro
);

   localparam logic [5:0] PC_INI = 6'(PC_INICIAL);
   localparam logic [5:0] ULTIMO = 6'(ULTIMO_ENDERECO);

   if (PROFUNDIDADE_PILHA < 1 || PROFUNDIDADE_PILHA > 8) begin : g_prof_invalida
      $error("PROFUNDIDADE_PILHA must be in 1..8");
   end

   typedef enum logic [1:0] {INICIO, EXECUTA, PARADO} estado_t;

   estado_t    estado, estado_prox;
   logic [5:0] pc_prox;
   logic       valido_prox;
   logic       erro_prox;

   function automatic logic [5:0] incrementa(input logic [5:0] endereco);
      return (endereco == ULTIMO) ? PC_INI : endereco + 6'd1;
   endfunction

`ifdef CONTADOR_PILHA_RETORNO_EN
   localparam int SP_W = $clog2(PROFUNDIDADE_PILHA + 1);

   // Storage is sized to the pointer range; entries at or above the depth are never written.
   logic [5:0]      pilha [(1 << SP_W)];
   logic [SP_W-1:0] sp;
   logic            empilha, desempilha, cheia, vazia;

   assign cheia = (sp == SP_W'(PROFUNDIDADE_PILHA));
   assign vazia = (sp == '0);

   always_ff @(posedge clk_PC or posedge reset) begin
      if (reset)           sp <= '0;
      else if (empilha)    sp <= sp + SP_W'(1);
      else if (desempilha) sp <= sp - SP_W'(1);
   end

   always_ff @(posedge clk_PC) begin
      if (empilha) pilha[sp] <= incrementa(pc);
   end
`else
   localparam bit PILHA_EN = 1'b0;
`endif

   always_ff @(posedge clk_PC or posedge reset) begin
      if (reset) begin
         estado    <= INICIO;
         pc        <= PC_INI;
         pc_valido <= 1'b0;
         erro      <= 1'b0;
      end else begin
         estado    <= estado_prox;
         pc        <= pc_prox;
         pc_valido <= valido_prox;
         erro      <= erro_prox;
      end
   end

   always_comb begin
      estado_prox = estado;
      pc_prox     = pc;
      valido_prox = pc_valido;
      erro_prox   = erro;
`ifdef CONTADOR_PILHA_RETORNO_EN
      empilha     = 1'b0;
      desempilha  = 1'b0;
`endif
      unique case (estado)
         INICIO: begin
            estado_prox = EXECUTA;
            valido_prox = 1'b1;
         end
         EXECUTA: begin
            valido_prox = 1'b1;
            if (parar) begin
               estado_prox = PARADO;
               valido_prox = 1'b0;
            end else if (stall) begin
               valido_prox = pc_valido;
`ifdef CONTADOR_PILHA_RETORNO_EN
            end else if (retorno) begin
               if (vazia) begin
                  erro_prox = 1'b1;
                  pc_prox   = incrementa(pc);
               end else begin
                  desempilha = 1'b1;
                  pc_prox    = pilha[sp - SP_W'(1)];
               end
            end else if (chamada) begin
               if (alvo > ULTIMO) begin
                  erro_prox = 1'b1;
               end else if (cheia) begin
                  erro_prox = 1'b1;
                  pc_prox   = incrementa(pc);
               end else begin
                  empilha = 1'b1;
                  pc_prox = alvo;
               end
            end else if (salto || desvio) begin
`else
            end else if (retorno && PILHA_EN) begin
               // retorno has no effect without the stack
               pc_prox = pc;
            end else if (chamada || salto || desvio) begin
`endif
               if (alvo > ULTIMO) erro_prox = 1'b1;
               else               pc_prox   = alvo;
            end else begin
               pc_prox = incrementa(pc);
            end
         end
         PARADO: begin
            valido_prox = 1'b0;
            if (retomar) begin
               estado_prox = EXECUTA;
               valido_prox = 1'b1;
            end
         end
         default: estado_prox = INICIO;
      endcase
   end

endmodule

// File: tb/tb_contador_programa.sv
// Randomized bench for contador_programa with a behavioural reference model and directed anchors.
module tb_contador_programa;

   localparam int ULT   = 41;
   localparam int DEPTH = 4;

   logic       clk_PC = 1'b0;
   logic       reset  = 1'b1;
   logic       stall = 1'b0, desvio = 1'b0, salto = 1'b0, chamada = 1'b0, retorno = 1'b0;
   logic       parar = 1'b0, retomar = 1'b0;
   logic [5:0] alvo = '0;
   logic [5:0] pc;
   logic       pc_valido, erro;

   int checks = 0;
   int errors = 0;

   contador_programa #(
      .PC_INICIAL(0), .ULTIMO_ENDERECO(ULT), .PROFUNDIDADE_PILHA(DEPTH)
   ) dut (
      .clk_PC(clk_PC), .reset(reset), .stall(stall), .desvio(desvio), .salto(salto),
      .chamada(chamada), .retorno(retorno), .alvo(alvo), .parar(parar), .retomar(retomar),
      .pc(pc), .pc_valido(pc_valido), .erro(erro)
   );

   always #5 clk_PC = ~clk_PC;

   // Reference model: what the counter must show, from the behavioural rules.
   int m_pc = 0;
   int m_valido = 0;
   int m_erro = 0;
   bit iniciado = 0;
   bit parado = 0;
   int pilha[$];

   function automatic int seguinte(input int a);
      return (a + 1) % (ULT + 1);
   endfunction

   task automatic modelo_reset();
      m_pc = 0; m_valido = 0; m_erro = 0;
      iniciado = 0; parado = 0;
      pilha.delete();
   endtask

   task automatic modelo_passo();
      if (!iniciado) begin
         iniciado = 1; m_valido = 1;
         return;
      end
      if (parado) begin
         if (retomar) begin parado = 0; m_valido = 1; end
         return;
      end
      if (parar) begin parado = 1; m_valido = 0; return; end
      if (stall) return;
      m_valido = 1;
`ifdef CONTADOR_PILHA_RETORNO_EN
      if (retorno) begin
         if (pilha.size() == 0) begin m_erro = 1; m_pc = seguinte(m_pc); end
         else m_pc = pilha.pop_back();
         return;
      end
      if (chamada) begin
         if (int'(alvo) > ULT) m_erro = 1;
         else if (pilha.size() == DEPTH) begin m_erro = 1; m_pc = seguinte(m_pc); end
         else begin pilha.push_back(seguinte(m_pc)); m_pc = int'(alvo); end
         return;
      end
      if (salto || desvio) begin
`else
      if (salto || desvio || chamada) begin
`endif
         if (int'(alvo) > ULT) m_erro = 1;
         else m_pc = int'(alvo);
         return;
      end
      m_pc = seguinte(m_pc);
   endtask

   always @(posedge clk_PC or posedge reset) begin
      if (reset) modelo_reset();
      else       modelo_passo();
   end

   task automatic verifica(input string nome, input int atual, input int esperado);
      checks++;
      if (atual != esperado) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
      end
   endtask

   always @(negedge clk_PC) begin
      verifica("model_pc", int'(pc), m_pc);
      verifica("model_pc_valido", int'(pc_valido), m_valido);
      verifica("model_erro", int'(erro), m_erro);
   end

   task automatic espera(input int n);
      repeat (n) @(posedge clk_PC);
      #1;
   endtask

   task automatic faz_reset();
      reset = 1'b1;
      {stall, desvio, salto, chamada, retorno, parar, retomar} = '0;
      espera(1);
      reset = 1'b0;
   endtask

   initial begin
      // Free run from reset: 43 edges.
      espera(2);
      reset = 1'b0;
      verifica("reset_pc", int'(pc), 0);
      verifica("reset_valido", int'(pc_valido), 0);
      verifica("reset_erro", int'(erro), 0);
      espera(1);
      verifica("inicio_pc", int'(pc), 0);
      verifica("inicio_valido", int'(pc_valido), 1);
      espera(41);
      verifica("run_last", int'(pc), 41);
      espera(1);
      verifica("run_wrap", int'(pc), 0);

      // Jump to valid and invalid targets.
      faz_reset();
      espera(6);
      verifica("pre_salto", int'(pc), 5);
      salto = 1'b1; alvo = 6'd20;
      espera(1);
      verifica("salto_20", int'(pc), 20);
      verifica("salto_erro0", int'(erro), 0);
      alvo = 6'd5;
      espera(1);
      alvo = 6'd50;
      espera(1);
      verifica("salto_bad_pc", int'(pc), 5);
      verifica("salto_bad_erro", int'(erro), 1);
      salto = 1'b0;
      espera(3);
      verifica("erro_sticky", int'(erro), 1);
      verifica("after_bad_pc", int'(pc), 8);

      // Stall priority, then halt and resume.
      faz_reset();
      espera(8);
      stall = 1'b1; salto = 1'b1; alvo = 6'd20;
      espera(1);
      verifica("stall_pc", int'(pc), 7);
      stall = 1'b0; salto = 1'b0; parar = 1'b1;
      espera(1);
      verifica("parar_pc", int'(pc), 7);
      verifica("parar_valido", int'(pc_valido), 0);
      parar = 1'b0; salto = 1'b1; alvo = 6'd2;
      espera(3);
      verifica("parado_pc", int'(pc), 7);
      verifica("parado_valido", int'(pc_valido), 0);
      salto = 1'b0; retomar = 1'b1;
      espera(1);
      verifica("retomar_pc", int'(pc), 7);
      verifica("retomar_valido", int'(pc_valido), 1);
      retomar = 1'b0;
      espera(1);
      verifica("retomar_next", int'(pc), 8);

`ifdef CONTADOR_PILHA_RETORNO_EN
      // Call/return and stack overflow.
      faz_reset();
      espera(4);
      chamada = 1'b1; alvo = 6'd30;
      espera(1);
      verifica("call_pc", int'(pc), 30);
      chamada = 1'b0;
      espera(1);
      verifica("call_next", int'(pc), 31);
      retorno = 1'b1;
      espera(1);
      verifica("ret_pc", int'(pc), 4);
      retorno = 1'b0;
      faz_reset();
      espera(1);
      chamada = 1'b1;
      for (int k = 0; k < 4; k++) begin
         alvo = 6'(20 + k);
         espera(1);
      end
      verifica("nest4_pc", int'(pc), 23);
      verifica("nest4_erro", int'(erro), 0);
      alvo = 6'd30;
      espera(1);
      verifica("overflow_pc", int'(pc), 24);
      verifica("overflow_erro", int'(erro), 1);
      chamada = 1'b0;
`else
      // Without the stack, chamada jumps and retorno is ignored.
      faz_reset();
      espera(4);
      chamada = 1'b1; alvo = 6'd30;
      espera(1);
      verifica("call_as_jump", int'(pc), 30);
      chamada = 1'b0; retorno = 1'b1;
      espera(1);
      verifica("ret_ignored_pc", int'(pc), 31);
      verifica("ret_ignored_erro", int'(erro), 0);
      retorno = 1'b0;
`endif

      // Asynchronous reset while halted.
      faz_reset();
      espera(13);
      verifica("pre_halt_pc", int'(pc), 12);
      salto = 1'b1; alvo = 6'd60;
      espera(1);
      verifica("halt_erro_set", int'(erro), 1);
      salto = 1'b0; parar = 1'b1;
      espera(1);
      parar = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      verifica("async_pc", int'(pc), 0);
      verifica("async_valido", int'(pc_valido), 0);
      verifica("async_erro", int'(erro), 0);
      espera(1);
      reset = 1'b0;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         stall   = ($urandom_range(0, 9) == 0);
         desvio  = ($urandom_range(0, 5) == 0);
         salto   = ($urandom_range(0, 7) == 0);
         chamada = ($urandom_range(0, 7) == 0);
         retorno = ($urandom_range(0, 7) == 0);
         parar   = ($urandom_range(0, 29) == 0);
         retomar = ($urandom_range(0, 3) == 0);
         alvo    = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(42, 63))
                                                 : 6'($urandom_range(0, 41));
         reset   = ($urandom_range(0, 199) == 0);
         espera(1);
      end
      reset = 1'b0;
      {stall, desvio, salto, chamada, retorno, parar, retomar} = '0;
      espera(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
